// File: rtl/link_upstream_credit_tx_pkg.sv
// Shared types and helpers for the multi-channel upstream credit transmitter.
package link_tx_pkg;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } tx_state_e;

  // Bit-lane number (in units of CH_W) that channel ch carries during a given beat.
  function automatic int lane_index(input int beat, input int ch, input int num_ch);
    return beat * num_ch + ch;
  endfunction

  function automatic bit params_ok(input int credits, input int beats, input int token_batch);
    return (beats >= 1) && (credits >= beats) && (token_batch <= credits);
  endfunction

endpackage

// File: rtl/link_upstream_credit_tx_if.sv
// Core-side handshake and link-side channel bundle of the upstream transmitter.
interface link_upstream_credit_tx_if #(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 8,
  parameter int BEATS   = 2,
  parameter int CREDITS = 64
);
  import link_tx_pkg::*;

  localparam int CORE_W = NUM_CH * CH_W * BEATS;
  localparam int CNT_W  = $clog2(CREDITS + 1);

  logic [CORE_W-1:0]      core_data_i;
  logic                   core_valid_i;
  logic                   core_ready_o;
  logic                   link_en_i;
  logic [NUM_CH-1:0]      token_i;
  logic [NUM_CH*CH_W-1:0] io_data_o;
  logic [NUM_CH-1:0]      io_valid_o;
  logic [CNT_W-1:0]       credit_min_o;
  logic                   busy_o;
  logic                   err_o;

  modport master (
    output core_data_i, core_valid_i, link_en_i, token_i,
    input  core_ready_o, io_data_o, io_valid_o, credit_min_o, busy_o, err_o
  );

  modport slave (
    input  core_data_i, core_valid_i, link_en_i, token_i,
    output core_ready_o, io_data_o, io_valid_o, credit_min_o, busy_o, err_o
  );

endinterface

// File: rtl/link_upstream_credit_tx_credit_ctr.sv
// Per-channel saturating credit counter with a sticky overflow flag.
module link_credit_ctr
  import link_tx_pkg::*;
#(
  parameter int CREDITS     = 64,
  parameter int TOKEN_BATCH = 8,
  parameter int BEATS       = 2,
  parameter int CNT_W       = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             consume,
  input  logic             token,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W:0] FULL   = (CNT_W+1)'(CREDITS);
  localparam logic [CNT_W:0] DEBIT  = (CNT_W+1)'(BEATS);
  localparam logic [CNT_W:0] REFILL = (CNT_W+1)'(TOKEN_BATCH);

  logic [CNT_W:0] sum;

  // One extra bit of headroom so a refill on a full counter is seen as overflow.
  always_comb begin
    sum = {1'b0, count};
    if (consume) sum = sum - DEBIT;
    if (token)   sum = sum + REFILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= FULL[CNT_W-1:0];
      overflow <= 1'b0;
    end else if (sum > FULL) begin
      count    <= FULL[CNT_W-1:0];
      overflow <= 1'b1;
    end else begin
      count    <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/link_upstream_credit_tx.sv
// Upstream link transmitter: splits core words into per-channel beats, metered by credits.
module link_upstream_credit_tx
  import link_tx_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 8,
  parameter int BEATS       = 2,
  parameter int CREDITS     = 64,
  parameter int TOKEN_BATCH = 8
) (
  input logic                     clk,
  input logic                     rst,
  link_upstream_credit_tx_if.slave lnk
);

  localparam int CORE_W = NUM_CH * CH_W * BEATS;
  localparam int LANE_W = NUM_CH * CH_W;
  localparam int CNT_W  = $clog2(CREDITS + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  if (!params_ok(CREDITS, BEATS, TOKEN_BATCH)) begin : g_param_err
    $error("link_upstream_credit_tx: need BEATS>=1, CREDITS>=BEATS, TOKEN_BATCH<=CREDITS");
  end

  tx_state_e         state;
  logic [BEAT_W-1:0] beat;
  logic [CORE_W-1:0] word_q;
  logic [LANE_W-1:0] io_data_q;
  logic [NUM_CH-1:0] io_valid_q;
  logic              busy_q;

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [CNT_W-1:0]  credit_min;
  logic              ready;
  logic              accept;

  logic [CORE_W-1:0] src_word;
  logic [BEAT_W-1:0] src_beat;
  logic [LANE_W-1:0] next_lanes;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    link_credit_ctr #(
      .CREDITS    (CREDITS),
      .TOKEN_BATCH(TOKEN_BATCH),
      .BEATS      (BEATS),
      .CNT_W      (CNT_W)
    ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .consume (accept),
      .token   (lnk.token_i[c]),
      .count   (cnt[c]),
      .overflow(ovf[c])
    );
  end

  always_comb begin
    credit_min = cnt[0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (cnt[c] < credit_min) credit_min = cnt[c];
    end
  end

  // A new word may start only in the slot where the previous one issues its last beat.
  assign ready  = !rst && lnk.link_en_i && (credit_min >= CNT_W'(BEATS)) &&
                  ((state == IDLE) || ((state == SEND) && (beat == BEAT_LAST)));
  assign accept = ready && lnk.core_valid_i;

  always_comb begin
    src_word   = word_q;
    src_beat   = (beat == BEAT_LAST) ? '0 : beat + 1'b1;
    next_lanes = '0;
    if (accept) begin
      src_word = lnk.core_data_i;
      src_beat = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      next_lanes[c*CH_W +: CH_W] = src_word[lane_index(int'(src_beat), c, NUM_CH)*CH_W +: CH_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      word_q     <= '0;
      io_data_q  <= '0;
      io_valid_q <= '0;
      busy_q     <= 1'b0;
    end else if (accept) begin
      state      <= SEND;
      beat       <= '0;
      word_q     <= lnk.core_data_i;
      io_data_q  <= next_lanes;
      io_valid_q <= '1;
      busy_q     <= 1'b1;
    end else if (state == SEND) begin
      if (beat == BEAT_LAST) begin
        state      <= IDLE;
        io_valid_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        beat      <= beat + 1'b1;
        io_data_q <= next_lanes;
      end
    end
  end

  assign lnk.core_ready_o = ready;
  assign lnk.io_data_o    = io_data_q;
  assign lnk.io_valid_o   = io_valid_q;
  assign lnk.credit_min_o = credit_min;
  assign lnk.busy_o       = busy_q;
  assign lnk.err_o        = |ovf;

endmodule

// File: tb/tb_link_upstream_credit_tx.sv
// Directed self-checking bench for link_upstream_credit_tx at default parameters.
module tb_link_upstream_credit_tx;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  link_upstream_credit_tx_if #(.NUM_CH(2), .CH_W(8), .BEATS(2), .CREDITS(64)) bus ();

  link_upstream_credit_tx #(
    .NUM_CH(2), .CH_W(8), .BEATS(2), .CREDITS(64), .TOKEN_BATCH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lnk(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wordOf(input int w);
    return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
  endfunction

  task automatic resetDut();
    rst               = 1'b1;
    bus.core_valid_i  = 1'b0;
    bus.core_data_i   = '0;
    bus.token_i       = '0;
    bus.link_en_i     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Streams n words with valid held high, then waits for the last word to drain.
  task automatic applyStimulus(input int n);
    int   acc;
    int   cyc;
    logic took;
    acc = 0;
    cyc = 0;
    bus.core_data_i  = wordOf(0);
    bus.core_valid_i = 1'b1;
    while (acc < n && cyc < n*4 + 20) begin
      #1;
      took = bus.core_ready_o;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        acc++;
        bus.core_data_i = wordOf(acc);
      end
    end
    bus.core_valid_i = 1'b0;
    checkOutput("stream_accept_count", 64'(acc), 64'(n));
    cyc = 0;
    while (bus.busy_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("stream_drained", 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst              = 1'b1;
    bus.core_valid_i = 1'b0;
    bus.core_data_i  = '0;
    bus.token_i      = '0;
    bus.link_en_i    = 1'b1;
    #2;
    checkOutput("reset_ready",      64'(bus.core_ready_o), 64'd0);
    checkOutput("reset_io_valid",   64'(bus.io_valid_o),   64'd0);
    checkOutput("reset_io_data",    64'(bus.io_data_o),    64'd0);
    checkOutput("reset_credit_min", 64'(bus.credit_min_o), 64'd64);
    checkOutput("reset_busy",       64'(bus.busy_o),       64'd0);
    checkOutput("reset_err",        64'(bus.err_o),        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word
    bus.core_data_i  = 32'hAABBCCDD;
    bus.core_valid_i = 1'b1;
    #1;
    checkOutput("single_ready", 64'(bus.core_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.core_valid_i = 1'b0;
    checkOutput("single_b0_valid",  64'(bus.io_valid_o),   64'h3);
    checkOutput("single_b0_data",   64'(bus.io_data_o),    64'hCCDD);
    checkOutput("single_credit",    64'(bus.credit_min_o), 64'd62);
    checkOutput("single_busy",      64'(bus.busy_o),       64'd1);
    @(posedge clk); #1;
    checkOutput("single_b1_valid",  64'(bus.io_valid_o),   64'h3);
    checkOutput("single_b1_data",   64'(bus.io_data_o),    64'hAABB);
    @(posedge clk); #1;
    checkOutput("single_idle_valid", 64'(bus.io_valid_o), 64'h0);
    checkOutput("single_idle_busy",  64'(bus.busy_o),     64'd0);
    checkOutput("single_idle_credit", 64'(bus.credit_min_o), 64'd62);

    // Back-to-back streaming until credits run out
    resetDut();
    bus.core_data_i  = wordOf(0);
    bus.core_valid_i = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      checkOutput("stream_valid", 64'(bus.io_valid_o), 64'h3);
      if (k % 2 == 0)
        checkOutput("stream_beat0", 64'(bus.io_data_o), {48'd0, 8'(2*k+1), 8'(2*k)});
      else
        checkOutput("stream_beat1", 64'(bus.io_data_o), {48'd0, 8'(2*k+1), 8'(2*k)});
      if (k % 2 == 0) bus.core_data_i = wordOf(k/2 + 1);
    end
    @(posedge clk); #1;
    checkOutput("exhaust_valid",  64'(bus.io_valid_o),   64'h0);
    checkOutput("exhaust_credit", 64'(bus.credit_min_o), 64'd0);
    checkOutput("exhaust_ready",  64'(bus.core_ready_o), 64'd0);
    bus.token_i = 2'b11;
    @(posedge clk); #1;
    bus.token_i = 2'b00;
    checkOutput("refill_credit", 64'(bus.credit_min_o), 64'd8);
    checkOutput("refill_ready",  64'(bus.core_ready_o), 64'd1);
    bus.core_valid_i = 1'b0;

    // Overflow on one channel is sticky
    resetDut();
    applyStimulus(1);
    checkOutput("ovf_pre_credit", 64'(bus.credit_min_o), 64'd62);
    checkOutput("ovf_pre_err",    64'(bus.err_o),        64'd0);
    bus.token_i = 2'b01;
    @(posedge clk); #1;
    bus.token_i = 2'b00;
    checkOutput("ovf_err",        64'(bus.err_o),        64'd1);
    checkOutput("ovf_credit_min", 64'(bus.credit_min_o), 64'd62);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovf_err_sticky", 64'(bus.err_o), 64'd1);

    // Simultaneous accept and token nets both
    resetDut();
    applyStimulus(27);
    checkOutput("sim_pre_credit", 64'(bus.credit_min_o), 64'd10);
    bus.core_data_i  = 32'h01020304;
    bus.core_valid_i = 1'b1;
    bus.token_i      = 2'b11;
    #1;
    checkOutput("sim_ready", 64'(bus.core_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.core_valid_i = 1'b0;
    bus.token_i      = 2'b00;
    checkOutput("sim_credit", 64'(bus.credit_min_o), 64'd16);
    checkOutput("sim_err",    64'(bus.err_o),        64'd0);

    // Link disable during beat 0
    resetDut();
    bus.core_data_i  = 32'h11223344;
    bus.core_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.link_en_i = 1'b0;
    #1;
    checkOutput("dis_ready",    64'(bus.core_ready_o), 64'd0);
    checkOutput("dis_b0_data",  64'(bus.io_data_o),    64'h3344);
    @(posedge clk); #1;
    checkOutput("dis_b1_valid", 64'(bus.io_valid_o),   64'h3);
    checkOutput("dis_b1_data",  64'(bus.io_data_o),    64'h1122);
    @(posedge clk); #1;
    checkOutput("dis_idle_valid", 64'(bus.io_valid_o), 64'h0);
    checkOutput("dis_idle_busy",  64'(bus.busy_o),     64'd0);
    @(posedge clk); #1;
    checkOutput("dis_no_accept", 64'(bus.credit_min_o), 64'd62);
    bus.core_valid_i = 1'b0;
    bus.link_en_i    = 1'b1;

    // Reset in the middle of a word, with err already set
    resetDut();
    bus.token_i = 2'b01;
    @(posedge clk); #1;
    bus.token_i = 2'b00;
    checkOutput("rstmid_err_set", 64'(bus.err_o), 64'd1);
    bus.core_data_i  = 32'hAABBCCDD;
    bus.core_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.core_valid_i = 1'b0;
    checkOutput("rstmid_busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_io_valid", 64'(bus.io_valid_o),   64'h0);
    checkOutput("rstmid_credit",   64'(bus.credit_min_o), 64'd64);
    checkOutput("rstmid_err",      64'(bus.err_o),        64'd0);
    checkOutput("rstmid_ready",    64'(bus.core_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rstmid_ready_after", 64'(bus.core_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
